// File: rtl/truth_table_capture.sv
// Sweeps every minterm of an N_IN-input combinational block, samples its 1-bit response and
// hands the assembled truth table off over valid/ready. Optional checker: TRUTH_TABLE_CAPTURE_EXPECT_EN.
module truth_table_capture #(
  parameter  int N_IN          = 4,
  parameter  int SETTLE_CYCLES = 1,
  localparam int TW            = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic [N_IN-1:0] abcd,
  input  logic            s,
  output logic [TW-1:0]   table_out,
  output logic [N_IN:0]   ones_count,
  output logic            table_valid,
  input  logic            table_ready
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
  ,
  input  logic [TW-1:0]   expected,
  output logic            mismatch,
  output logic [TW-1:0]   mismatch_mask
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_t;

  localparam logic [3:0]      SETTLE   = 4'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  state_t          r_state, w_state_next;
  logic [N_IN-1:0] r_idx, w_idx_next;
  logic [3:0]      r_wait, w_wait_next;
  logic [TW-1:0]   r_table, w_table_next;
  logic [N_IN:0]   r_ones, w_ones_next;
  logic            r_valid, w_valid_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_wait  <= '0;
      r_table <= '0;
      r_ones  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_wait  <= w_wait_next;
      r_table <= w_table_next;
      r_ones  <= w_ones_next;
      r_valid <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_wait_next  = r_wait;
    w_table_next = r_table;
    w_ones_next  = r_ones;
    w_valid_next = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SWEEP;
          w_idx_next   = '0;
          w_wait_next  = '0;
          w_table_next = '0;
          w_ones_next  = '0;
        end
      end
      ST_SWEEP: begin
        if (r_wait != SETTLE) begin
          w_wait_next = r_wait + 4'd1;
        end else begin
          // Last edge of this minterm's hold window: the FUT output has settled.
          w_table_next[r_idx] = s;
          w_ones_next         = r_ones + {{N_IN{1'b0}}, s};
          w_wait_next         = '0;
          if (r_idx == LAST_IDX) begin
            w_state_next = ST_DONE;
            w_valid_next = 1'b1;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (table_ready) begin
          w_state_next = ST_IDLE;
          w_valid_next = 1'b0;
          w_idx_next   = '0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign busy        = (r_state != ST_IDLE);
  assign abcd        = r_idx;
  assign table_out   = r_table;
  assign ones_count  = r_ones;
  assign table_valid = r_valid;

`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
  logic [TW-1:0] r_expected;
  logic          r_mismatch;
  logic [TW-1:0] r_mismatch_mask;
  logic          w_start_acc;
  logic          w_enter_done;
  logic [TW-1:0] w_diff;

  assign w_start_acc  = (r_state == ST_IDLE) && start;
  assign w_enter_done = (r_state == ST_SWEEP) && (w_state_next == ST_DONE);
  // Compare against the table including the bit captured on this same edge.
  assign w_diff       = w_table_next ^ r_expected;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_expected      <= '0;
      r_mismatch      <= 1'b0;
      r_mismatch_mask <= '0;
    end else if (w_start_acc) begin
      r_expected      <= expected;
      r_mismatch      <= 1'b0;
      r_mismatch_mask <= '0;
    end else if (w_enter_done) begin
      r_mismatch      <= |w_diff;
      r_mismatch_mask <= w_diff;
    end
  end

  assign mismatch      = r_mismatch;
  assign mismatch_mask = r_mismatch_mask;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Self-checking bench for truth_table_capture: vector table of FUTs plus hand-written corner sequences.
module tb_truth_table_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // Instance A: N_IN=4, SETTLE_CYCLES=1
  logic        start_a, busy_a, s_a, valid_a, ready_a;
  logic [3:0]  abcd_a;
  logic [15:0] table_a;
  logic [4:0]  ones_a;
  // Instance B: N_IN=4, SETTLE_CYCLES=0
  logic        start_b, busy_b, s_b, valid_b, ready_b;
  logic [3:0]  abcd_b;
  logic [15:0] table_b;
  logic [4:0]  ones_b;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
  logic [15:0] expected_a, mm_mask_a, mm_mask_b;
  logic        mm_a, mm_b;
`endif

  // FUT model: mode 0 = the reference boolean expression, mode 1 = arbitrary lookup mask
  int          fut_mode;
  logic [15:0] fut_mask;
  always_comb begin
    if (fut_mode == 0)
      s_a = (~abcd_a[3] & abcd_a[2] & abcd_a[1] & abcd_a[0]) |
            (abcd_a[3] & ~abcd_a[1] & abcd_a[0]) |
            (abcd_a[3] & abcd_a[1] & ~abcd_a[0]) |
            (abcd_a[3] & abcd_a[0] & ~abcd_a[2]);
    else
      s_a = fut_mask[abcd_a];
  end
  assign s_b = abcd_b[0];

  truth_table_capture #(.N_IN(4), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .abcd(abcd_a), .s(s_a),
    .table_out(table_a), .ones_count(ones_a), .table_valid(valid_a), .table_ready(ready_a)
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
    , .expected(expected_a), .mismatch(mm_a), .mismatch_mask(mm_mask_a)
`endif
  );

  truth_table_capture #(.N_IN(4), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .abcd(abcd_b), .s(s_b),
    .table_out(table_b), .ones_count(ones_b), .table_valid(valid_b), .table_ready(ready_b)
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
    , .expected(16'h0000), .mismatch(mm_b), .mismatch_mask(mm_mask_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: truth table of a lookup-mask FUT, built minterm by minterm
  function automatic logic [15:0] model_table(input logic [15:0] mask);
    logic [15:0] t = '0;
    for (int k = 0; k < 16; k++) t[k] = mask[k];
    return t;
  endfunction

  // One full sweep on instance A; ready held low for ready_delay cycles after valid
  task automatic run_sweep(input string tag, input logic [15:0] exp_t, input int exp_o,
                           input int ready_delay);
    int n, bad;
    ready_a = (ready_delay == 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy_a), 64'd1);
    n = 0; bad = 0;
    while (!valid_a && n < 200) begin
      tick();
      n++;
      if (!valid_a && abcd_a !== 4'(n / 2)) bad++;
    end
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_abcd_hold"}, 64'(bad), 64'd0);
    check({tag, "_table"}, 64'(table_a), 64'(exp_t));
    check({tag, "_ones"}, 64'(ones_a), 64'(exp_o));
    if (ready_delay > 0) begin
      repeat (ready_delay) tick();
      check({tag, "_valid_held"}, 64'(valid_a), 64'd1);
      ready_a = 1'b1;
    end
    tick();
    check({tag, "_idle_after_hs"}, {61'd0, valid_a, busy_a, |abcd_a}, 64'd0);
    check({tag, "_table_retained"}, 64'(table_a), 64'(exp_t));
  endtask

  typedef struct {
    int          mode;
    logic [15:0] mask;
    logic [15:0] exp_table;
    int          exp_ones;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int n, bad;
    logic [15:0] m;
    reset = 1'b1; start_a = 0; start_b = 0; ready_a = 1; ready_b = 1;
    fut_mode = 0; fut_mask = '0;
`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
    expected_a = '0;
`endif
    vecs[0] = '{0, 16'h0000, 16'h6E80, 6};
    vecs[1] = '{1, 16'h0000, 16'h0000, 0};
    vecs[2] = '{1, 16'hFFFF, 16'hFFFF, 16};
    for (int i = 3; i < 7; i++) begin
      m = 16'($urandom);
      vecs[i] = '{1, m, model_table(m), $countones(m)};
    end

    tick(); tick();
    check("reset_state_a", {busy_a, valid_a, abcd_a, table_a, ones_a}, 64'd0);
    reset = 1'b0;
    tick();

    // Vector table: each FUT swept once, random ready backpressure on the random ones
    for (int i = 0; i < 7; i++) begin
      fut_mode = vecs[i].mode;
      fut_mask = vecs[i].mask;
      run_sweep($sformatf("vec%0d", i), vecs[i].exp_table, vecs[i].exp_ones,
                (i < 3) ? 0 : int'($urandom_range(0, 3)));
    end

    // SETTLE_CYCLES=0, s = d: abcd steps every edge
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0; bad = 0;
    while (!valid_b && n < 200) begin
      tick();
      n++;
      if (!valid_b && abcd_b !== 4'(n)) bad++;
    end
    check("s0_latency", 64'(n), 64'd16);
    check("s0_abcd_step", 64'(bad), 64'd0);
    check("s0_table", 64'(table_b), 64'hAAAA);
    check("s0_ones", 64'(ones_b), 64'd8);
    tick();
    check("s0_idle", {62'd0, valid_b, busy_b}, 64'd0);

    // Stall in DONE with start pulsed; then start coincident with handshake
    fut_mode = 0;
    ready_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!valid_a && n < 200) begin tick(); n++; end
    check("stall_latency", 64'(n), 64'd32);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      start_a = (c == 3);
      tick();
      if (!valid_a || !busy_a || table_a !== 16'h6E80 || abcd_a !== 4'd15 || ones_a !== 5'd6) bad++;
    end
    start_a = 1'b0;
    check("stall_stable", 64'(bad), 64'd0);
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("hs_with_start_idle", {62'd0, valid_a, busy_a}, 64'd0);
    tick();
    check("start_not_honoured", 64'(busy_a), 64'd0);

    // Reset on edge 9 of a sweep
    fut_mode = 1; fut_mask = 16'hFFFF;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (8) tick();
    check("pre_reset_partial", 64'(ones_a), 64'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_outputs", {busy_a, valid_a, abcd_a, table_a, ones_a}, 64'd0);
    fut_mode = 0;
    run_sweep("after_reset", 16'h6E80, 6, 0);

`ifdef TRUTH_TABLE_CAPTURE_EXPECT_EN
    for (int e = 0; e < 2; e++) begin
      expected_a = (e == 0) ? 16'h6E80 : 16'h6E81;
      ready_a = 1'b0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      expected_a = 16'h1234;  // must have been latched at start
      n = 0;
      while (!valid_a && n < 200) begin tick(); n++; end
      check($sformatf("exp%0d_mismatch", e), 64'(mm_a), 64'(e));
      check($sformatf("exp%0d_mask", e), 64'(mm_mask_a), 64'(e));
      ready_a = 1'b1;
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
